sipo_frame_ctrl: RTL
====================

SIPO_FRAME_CTRL -- requirements
Module: sipo_frame_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving data bits per frame (legal range 2..16).
REQ-002 The block SHALL have parameter PARITY_EN, default 1: 1 = one even-parity bit follows the data, 0 = no parity bit.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port serial_in, input, 1 bit: serial line, idle high.
REQ-006 The block SHALL have port bit_en, input, 1 bit: bit strobe; serial_in is sampled only in cycles where bit_en=1.
REQ-007 The block SHALL have port frame_ready, input, 1 bit: consumer accepts frame_data in any cycle where frame_valid=1 and frame_ready=1.
REQ-008 The block SHALL have port frame_data, output, DATA_W bits: last delivered frame.
REQ-009 The block SHALL have port frame_valid, output, 1 bit: frame_data holds an unconsumed frame.
REQ-010 The block SHALL have port parity_err, output, 1 bit: parity status of the frame in frame_data; 0 when PARITY_EN=0.
REQ-011 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse on a bad stop bit.
REQ-012 The block SHALL have port overrun, output, 1 bit: one-cycle pulse when a completed frame is dropped.
REQ-013 The block SHALL have port busy, output, 1 bit: 1 whenever the receive FSM is not in IDLE.

Function
REQ-014 The receive FSM SHALL have states IDLE, SHIFT, PARITY, STOP; it advances only in bit_en=1 cycles, and all bit_en=0 cycles leave state, counter and shift register unchanged.
REQ-015 IDLE: a sample of serial_in=0 (start bit) SHALL go to SHIFT and clear the bit counter; a sample of 1 SHALL stay in IDLE.
REQ-016 SHIFT: each sample SHALL update shreg <= {shreg[DATA_W-2:0], serial_in} (first bit ends in the MSB) and increment the counter; the DATA_W-th sample SHALL go to PARITY if PARITY_EN=1, else to STOP.
REQ-017 PARITY: the sample SHALL be stored as the parity bit, then go to STOP; the error flag is the XOR of the DATA_W data bits and the parity bit (1 = odd total = error).
REQ-018 STOP: a sample of 1 SHALL deliver the frame (REQ-019/020); a sample of 0 SHALL pulse frame_err for the next cycle and discard the frame. Both cases return to IDLE.
REQ-019 Delivery, when frame_valid=0, or when frame_valid=1 and frame_ready=1 in the same cycle: frame_data, parity_err and frame_valid=1 SHALL be registered, so frame_valid rises the cycle after the stop-bit sample (latency 1).
REQ-020 Delivery with frame_valid=1 and frame_ready=0: the new frame SHALL be dropped; frame_data and parity_err SHALL be unchanged; overrun SHALL pulse for one cycle.
REQ-021 frame_valid SHALL remain high, with frame_data and parity_err stable, until a cycle with frame_ready=1; it SHALL then clear on the next edge unless a delivery occurs in that same cycle.
REQ-022 The receiver SHALL accept a new start bit in the first bit_en cycle after returning to IDLE, independent of the output handshake (one-deep output buffer).
REQ-023 frame_err and overrun SHALL never be asserted for more than one cycle per event.

Reset
REQ-024 With reset=1 at a clock edge, the block SHALL set FSM=IDLE, counter=0, shreg=0, frame_data=0, frame_valid=0, parity_err=0, frame_err=0, overrun=0, busy=0.
REQ-025 Reset SHALL take priority over every other input; a frame in progress SHALL be discarded without frame_err or overrun.

Verification (DATA_W=8, PARITY_EN=1, bit_en every 4th cycle unless noted)
REQ-026 Stimulus: start 0, data 1,0,1,0,0,1,0,1, parity 0, stop 1 -> frame_data=8'hA5, frame_valid rises the cycle after the stop sample, parity_err=0, busy=0 after stop.
REQ-027 Stimulus: same frame with parity bit 1 -> frame_data=8'hA5, parity_err=1.
REQ-028 Stimulus: frame with stop bit 0 -> frame_err pulses one cycle, frame_valid stays 0.
REQ-029 Stimulus: frame_ready=0 after 8'hA5 is delivered, then frame 8'h3C completes -> overrun pulses and frame_data stays 8'hA5. Repeat with frame_ready=1 in the delivery cycle -> no overrun, frame_data=8'h3C, frame_valid stays 1.
REQ-030 Stimulus: reset=1 for one cycle after 4 data bits -> all outputs 0; a following 8'h5A frame is received correctly.
REQ-031 Stimulus: serial_in toggles randomly during bit_en=0 cycles of an 8'hC3 frame -> frame_data=8'hC3, parity_err=0.

Source files
------------

// File: rtl/sipo_frame_ctrl.sv
// Serial-in, parallel-out frame receiver with a one-deep output buffer.
// Frames are a start bit (0), DATA_W data bits sent first bit first, an
// optional even-parity bit, and a stop bit (1). The line is sampled only on
// bit_en strobes. A completed frame is held in frame_data until the consumer
// takes it through the valid/ready handshake.
//
// Receive FSM states
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   S_IDLE   | line idle, waiting for a start-bit sample of 0
//   S_SHIFT  | collecting data bits into shreg, first bit ends in the MSB
//   S_PARITY | capturing the parity bit (only when PARITY_EN != 0)
//   S_STOP   | checking the stop bit, then delivering, dropping or flagging

module sipo_frame_ctrl #(
    parameter int DATA_W    = 8,
    parameter int PARITY_EN = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              serial_in,
    input  logic              bit_en,
    input  logic              frame_ready,
    output logic [DATA_W-1:0] frame_data,
    output logic              frame_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun,
    output logic              busy
);

    // One spare bit so the counter can represent DATA_W itself.
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic              par_bit;
    logic              frame_perr;
    logic              can_deliver;

    // Even parity over data plus parity bit; forced low when parity is disabled.
    assign frame_perr  = (PARITY_EN != 0) ? (^shreg ^ par_bit) : 1'b0;

    // The buffer is free if empty, or if its frame is being consumed this cycle.
    assign can_deliver = !frame_valid || frame_ready;

    // busy follows the state register directly, so it is glitch-free.
    assign busy = (state != S_IDLE);

    // Receive FSM plus the registered output buffer and event pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            bit_cnt     <= '0;
            shreg       <= '0;
            par_bit     <= 1'b0;
            frame_data  <= '0;
            frame_valid <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            // Event flags are single-cycle pulses unless re-armed below.
            frame_err <= 1'b0;
            overrun   <= 1'b0;

            // Consumed frame leaves the buffer; a same-cycle delivery below
            // overrides this and keeps frame_valid high.
            if (frame_valid && frame_ready) begin
                frame_valid <= 1'b0;
            end

            if (bit_en) begin
                case (state)
                    S_IDLE: begin
                        if (!serial_in) begin
                            state   <= S_SHIFT;
                            bit_cnt <= '0;
                        end
                    end

                    S_SHIFT: begin
                        shreg   <= {shreg[DATA_W-2:0], serial_in};
                        bit_cnt <= bit_cnt + CNT_W'(1);
                        if (bit_cnt == LAST_BIT) begin
                            state <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
                        end
                    end

                    S_PARITY: begin
                        par_bit <= serial_in;
                        state   <= S_STOP;
                    end

                    S_STOP: begin
                        state <= S_IDLE;
                        if (serial_in) begin
                            if (can_deliver) begin
                                frame_data  <= shreg;
                                parity_err  <= frame_perr;
                                frame_valid <= 1'b1;
                            end else begin
                                // Buffer still owned by the consumer: drop the
                                // new frame, keep the old one intact.
                                overrun <= 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end

                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
